sar_search: RTL

Successive-approximation search controller that drives the candidate operand of an external magnitude comparator and reads back its result. It finds an unknown target by binary search, one bit per comparison, MSB first. Each start command produces one WIDTH-bit result in WIDTH comparison steps, with a done pulse. It sits on the candidate side of the comparator datapath and acts as the companion to the 8-bit comparator block.

---
 rtl/sar_search_if.sv | 35 +++
 rtl/sar_search.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sar_search_if.sv
// sar_search_if: the start/abort command, the comparator feedback and the
// search results exchanged between a search controller and its user.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             cmp_ge;
  logic [WIDTH-1:0] cand;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             done;

  // User side: issues commands, models the comparator, observes progress.
  modport master (
    output start,
    output abort,
    output cmp_ge,
    input  cand,
    input  busy,
    input  result,
    input  done
  );

  // Controller side.
  modport slave (
    input  start,
    input  abort,
    input  cmp_ge,
    output cand,
    output busy,
    output result,
    output done
  );
endinterface

// File: rtl/sar_search.sv
// sar_search: successive-approximation controller. Drives a trial value to an
// external magnitude comparator and resolves one bit per decide step, MSB
// first. Each decide waits CMP_LAT cycles after the trial value changed.
module sar_search #(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_search_if.slave bus
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  localparam logic [KW-1:0]    K_INIT    = KW'(WIDTH - 1);
  localparam logic [KW-1:0]    K_ZERO    = {KW{1'b0}};
  localparam logic [KW-1:0]    K_ONE     = KW'(1);
  localparam logic [CW-1:0]    CNT_INIT  = CW'(CMP_LAT - 1);
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] CAND_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CAND_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cand_r, cand_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [KW-1:0]    k_r, k_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;

  // State register of the search FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers, all updated from the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r   <= CAND_ZERO;
      result_r <= CAND_ZERO;
      k_r      <= K_INIT;
      cnt_r    <= CNT_ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      cand_r   <= cand_s;
      result_r <= result_s;
      k_r      <= k_s;
      cnt_r    <= cnt_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state logic: start/abort handling, latency countdown, bit decisions.
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    result_s = result_r;
    k_s      = k_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // abort has no meaning here, so start alone decides.
        if (bus.start) begin
          state_s = ST_SEARCH;
          cand_s  = CAND_INIT;
          k_s     = K_INIT;
          cnt_s   = CNT_INIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (bus.abort) begin
          // Cancel without touching the last completed result.
          state_s = ST_IDLE;
          cand_s  = CAND_ZERO;
        end else if (cnt_r != CNT_ZERO) begin
          // Comparator still settling on the current trial value.
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          // Decide edge: keep or clear the trial bit.
          cand_s[k_r] = bus.cmp_ge;
          if (k_r != K_ZERO) begin
            cand_s[k_r - K_ONE] = 1'b1;
            k_s                 = k_r - K_ONE;
            cnt_s               = CNT_INIT;
          end else begin
            result_s = cand_s;
            done_s   = 1'b1;
            state_s  = ST_IDLE;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        cand_s  = CAND_ZERO;
      end
    endcase
    busy_s = (state_s == ST_SEARCH);
  end

  assign bus.cand   = cand_r;
  assign bus.result = result_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;

endmodule
